// File: rtl/vrvv_pkg.sv
// rtl/vrvv_pkg.sv - shared encodings, state type and register-group arithmetic helpers
package vrvv_pkg;

   localparam int VLEN    = 64;
   localparam int VL_W    = 7;
   localparam int NREG    = 32;
   localparam int REG_W   = $clog2(NREG);
   localparam int EPR_MAX = VLEN / 8;

   localparam logic [2:0] SEW_8     = 3'b000;
   localparam logic [2:0] SEW_16    = 3'b001;
   localparam logic [2:0] SEW_32    = 3'b010;
   localparam logic [2:0] SEW_64    = 3'b011;

   localparam logic [2:0] LMUL_1    = 3'b000;
   localparam logic [2:0] LMUL_2    = 3'b001;
   localparam logic [2:0] LMUL_4    = 3'b010;
   localparam logic [2:0] LMUL_8    = 3'b011;
   localparam logic [2:0] LMUL_RSVD = 3'b100;

   typedef enum logic {IDLE, ISSUE} state_t;

   // Fractional and reserved encodings occupy a single register.
   function automatic logic [3:0] lmul_regs(input logic [2:0] enc);
      case (enc)
         LMUL_1:  return 4'd1;
         LMUL_2:  return 4'd2;
         LMUL_4:  return 4'd4;
         LMUL_8:  return 4'd8;
         default: return 4'd1;
      endcase
   endfunction

   function automatic logic [3:0] elems_per_reg(input logic [2:0] sew_enc);
      case (sew_enc)
         SEW_8:   return 4'(EPR_MAX);
         SEW_16:  return 4'(EPR_MAX / 2);
         SEW_32:  return 4'(EPR_MAX / 4);
         SEW_64:  return 4'(EPR_MAX / 8);
         default: return 4'd1;
      endcase
   endfunction

   function automatic logic is_aligned(input logic [REG_W-1:0] r, input logic [3:0] l);
      return (r & REG_W'(l - 4'd1)) == '0;
   endfunction

endpackage

// File: rtl/vgroup_legal_check.sv
// rtl/vgroup_legal_check.sv - combinational legality and group-size decode for one instruction
import vrvv_pkg::*;

module vgroup_legal_check (
   input  logic [2:0]       i_sew,
   input  logic [2:0]       i_lmul,
   input  logic [REG_W-1:0] i_vs1,
   input  logic [REG_W-1:0] i_vs2,
   input  logic [REG_W-1:0] i_vd,
   input  logic [VL_W-1:0]  i_vl,
   output logic             o_illegal,
   output logic [3:0]       o_lregs,
   output logic [3:0]       o_epr,
   output logic [3:0]       o_nuops,
   output logic [VL_W-1:0]  o_vl_eff
);

   logic [VL_W-1:0] w_max;
   logic [VL_W-1:0] w_round;

   always_comb begin
      o_lregs  = lmul_regs(i_lmul);
      o_epr    = elems_per_reg(i_sew);
      w_max    = VL_W'(o_lregs) * VL_W'(o_epr);
      o_vl_eff = (i_vl < w_max) ? i_vl : w_max;
      // epr is a power of two, so the ceiling divide is a shift by log2(epr).
      w_round  = o_vl_eff + VL_W'(o_epr) - VL_W'(1);
      o_nuops  = 4'(w_round >> (2'd3 - i_sew[1:0]));
      o_illegal = (i_sew > SEW_64) || (i_lmul == LMUL_RSVD) ||
                  !is_aligned(i_vs1, o_lregs) || !is_aligned(i_vs2, o_lregs) ||
                  !is_aligned(i_vd, o_lregs);
   end

endmodule

// File: rtl/vgroup_sequencer.sv
// rtl/vgroup_sequencer.sv - splits one grouped vector instruction into per-register micro-ops
import vrvv_pkg::*;

module vgroup_sequencer (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [REG_W-1:0] in_vs1,
   input  logic [REG_W-1:0] in_vs2,
   input  logic [REG_W-1:0] in_vd,
   input  logic [2:0]       in_sew,
   input  logic [2:0]       in_lmul,
   input  logic [VL_W-1:0]  in_vl,
   output logic             uop_valid,
   input  logic             uop_ready,
   output logic [3:0]       uop_op,
   output logic [REG_W-1:0] uop_vs1,
   output logic [REG_W-1:0] uop_vs2,
   output logic [REG_W-1:0] uop_vd,
   output logic [2:0]       uop_idx,
   output logic [3:0]       uop_elems,
   output logic             uop_last,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           r_state, w_next;
   logic [3:0]       r_op;
   logic [REG_W-1:0] r_vs1, r_vs2, r_vd;
   logic [2:0]       r_idx;
   logic [3:0]       r_epr, r_nuops;
   logic [VL_W-1:0]  r_rem;
   logic             r_done, r_err;

   logic             w_illegal;
   logic [3:0]       w_lregs, w_epr, w_nuops;
   logic [VL_W-1:0]  w_vl_eff;
   logic             w_accept, w_hs, w_last, w_issue;
   logic [3:0]       w_elems;

   vgroup_legal_check u_legal (
      .i_sew     (in_sew),
      .i_lmul    (in_lmul),
      .i_vs1     (in_vs1),
      .i_vs2     (in_vs2),
      .i_vd      (in_vd),
      .i_vl      (in_vl),
      .o_illegal (w_illegal),
      .o_lregs   (w_lregs),
      .o_epr     (w_epr),
      .o_nuops   (w_nuops),
      .o_vl_eff  (w_vl_eff)
   );

   assign w_issue  = (r_state == ISSUE);
   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_hs     = w_issue && uop_ready;
   assign w_last   = ({1'b0, r_idx} == (r_nuops - 4'd1));
   assign w_elems  = (r_rem < VL_W'(r_epr)) ? r_rem[3:0] : r_epr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept && !w_illegal && (w_vl_eff != '0)) w_next = ISSUE;
         ISSUE:   if (w_hs && w_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= '0;
         r_vs1   <= '0;
         r_vs2   <= '0;
         r_vd    <= '0;
         r_idx   <= '0;
         r_epr   <= '0;
         r_nuops <= '0;
         r_rem   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_accept) begin
            r_err   <= w_illegal;
            r_done  <= !w_illegal && (in_vl == '0);
            r_op    <= in_op;
            r_vs1   <= in_vs1;
            r_vs2   <= in_vs2;
            r_vd    <= in_vd;
            r_idx   <= '0;
            r_epr   <= w_epr;
            r_nuops <= w_nuops;
            r_rem   <= w_vl_eff;
         end
         if (w_hs) begin
            if (w_last) begin
               r_done <= 1'b1;
            end else begin
               r_idx <= r_idx + 3'd1;
               r_rem <= r_rem - VL_W'(r_epr);
            end
         end
      end
   end

   // Micro-op fields read as zero whenever no micro-op is being offered.
   assign uop_valid = w_issue;
   assign uop_op    = w_issue ? r_op : '0;
   assign uop_vs1   = w_issue ? r_vs1 + REG_W'(r_idx) : '0;
   assign uop_vs2   = w_issue ? r_vs2 + REG_W'(r_idx) : '0;
   assign uop_vd    = w_issue ? r_vd + REG_W'(r_idx) : '0;
   assign uop_idx   = w_issue ? r_idx : '0;
   assign uop_elems = w_issue ? w_elems : '0;
   assign uop_last  = w_issue && w_last;
   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_vgroup_sequencer.sv
// tb/tb_vgroup_sequencer.sv - self-checking bench for vgroup_sequencer against an arithmetic model
module tb_vgroup_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_op = '0;
   logic [4:0] in_vs1 = '0, in_vs2 = '0, in_vd = '0;
   logic [2:0] in_sew = '0, in_lmul = '0;
   logic [6:0] in_vl = '0;
   logic       uop_valid;
   logic       uop_ready = 1'b1;
   logic [3:0] uop_op;
   logic [4:0] uop_vs1, uop_vs2, uop_vd;
   logic [2:0] uop_idx;
   logic [3:0] uop_elems;
   logic       uop_last, busy, done, err;

   int n_cmp = 0;
   int n_mis = 0;

   vgroup_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_vs1    (in_vs1),
      .in_vs2    (in_vs2),
      .in_vd     (in_vd),
      .in_sew    (in_sew),
      .in_lmul   (in_lmul),
      .in_vl     (in_vl),
      .uop_valid (uop_valid),
      .uop_ready (uop_ready),
      .uop_op    (uop_op),
      .uop_vs1   (uop_vs1),
      .uop_vs2   (uop_vs2),
      .uop_vd    (uop_vd),
      .uop_idx   (uop_idx),
      .uop_elems (uop_elems),
      .uop_last  (uop_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_uop(input int op, input int vs1, input int vs2, input int vd,
                            input int i, input int el, input int last);
      chk("uop_valid", 32'(uop_valid), 1);
      chk("uop_op",    32'(uop_op), op);
      chk("uop_vs1",   32'(uop_vs1), vs1 + i);
      chk("uop_vs2",   32'(uop_vs2), vs2 + i);
      chk("uop_vd",    32'(uop_vd), vd + i);
      chk("uop_idx",   32'(uop_idx), i);
      chk("uop_elems", 32'(uop_elems), el);
      chk("uop_last",  32'(uop_last), last);
      chk("busy",      32'(busy), 1);
      chk("in_ready_busy", 32'(in_ready), 0);
   endtask

   task automatic run_instr(input int op, input int vs1, input int vs2, input int vd,
                            input int sew, input int lmul, input int vl,
                            input int stall_idx, input int stall_cyc);
      int  L, epr, maxe, vle, nu, el;
      bit  bad;
      L    = (lmul == 1) ? 2 : (lmul == 2) ? 4 : (lmul == 3) ? 8 : 1;
      bad  = (sew > 3) || (lmul == 4) || (vs1 % L != 0) || (vs2 % L != 0) || (vd % L != 0);
      epr  = bad ? 1 : (8 >> sew);
      maxe = L * epr;
      vle  = (vl < maxe) ? vl : maxe;
      nu   = (vle + epr - 1) / epr;

      chk("in_ready_idle", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_op    = 4'(op);
      in_vs1   = 5'(vs1);
      in_vs2   = 5'(vs2);
      in_vd    = 5'(vd);
      in_sew   = 3'(sew);
      in_lmul  = 3'(lmul);
      in_vl    = 7'(vl);
      step();
      if (bad) begin
         in_valid = 1'b0;
         chk("err_pulse", 32'(err), 1);
         chk("err_no_done", 32'(done), 0);
         chk("err_no_uop", 32'(uop_valid), 0);
         chk("err_in_ready", 32'(in_ready), 1);
      end else if (nu == 0) begin
         in_valid = 1'b0;
         chk("vl0_done", 32'(done), 1);
         chk("vl0_no_err", 32'(err), 0);
         chk("vl0_no_uop", 32'(uop_valid), 0);
         chk("vl0_in_ready", 32'(in_ready), 1);
      end else begin
         // Offer junk while busy; it must not disturb the running group.
         in_op  = 4'($urandom);
         in_vd  = 5'($urandom);
         in_vl  = 7'($urandom);
         in_sew = 3'($urandom);
         chk("first_no_done", 32'(done), 0);
         chk("first_no_err", 32'(err), 0);
         for (int i = 0; i < nu; i++) begin
            el = (vle - i * epr < epr) ? (vle - i * epr) : epr;
            if (i == stall_idx && stall_cyc > 0) begin
               uop_ready = 1'b0;
               repeat (stall_cyc) begin
                  check_uop(op, vs1, vs2, vd, i, el, (i == nu - 1) ? 1 : 0);
                  step();
               end
               uop_ready = 1'b1;
            end
            check_uop(op, vs1, vs2, vd, i, el, (i == nu - 1) ? 1 : 0);
            step();
         end
         in_valid = 1'b0;
         chk("done_pulse", 32'(done), 1);
         chk("done_no_err", 32'(err), 0);
         chk("done_no_uop", 32'(uop_valid), 0);
         chk("done_idle", 32'(busy), 0);
         chk("done_in_ready", 32'(in_ready), 1);
      end
   endtask

   initial begin
      int sew, lmul, L, b1, b2, b3;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_uop_valid", 32'(uop_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_uop_vd", 32'(uop_vd), 0);
      chk("rst_uop_elems", 32'(uop_elems), 0);
      rst = 1'b0;
      step();

      run_instr(1, 2, 3, 4, 0, 0, 5, 9, 0);
      run_instr(2, 8, 12, 16, 2, 2, 7, 9, 0);
      run_instr(3, 0, 16, 8, 1, 3, 20, 1, 3);
      run_instr(4, 2, 4, 5, 0, 1, 9, 9, 0);
      run_instr(5, 0, 0, 0, 4, 0, 3, 9, 0);
      run_instr(6, 8, 16, 24, 1, 2, 0, 9, 0);
      run_instr(7, 0, 8, 16, 0, 3, 70, 9, 0);
      run_instr(8, 3, 5, 7, 3, 6, 5, 9, 0);
      run_instr(9, 4, 4, 4, 0, 4, 5, 9, 0);

      // Asynchronous reset in the middle of a four-register group.
      in_valid = 1'b1;
      in_op = 4'd3; in_vs1 = 5'd8; in_vs2 = 5'd12; in_vd = 5'd16;
      in_sew = 3'd2; in_lmul = 3'd2; in_vl = 7'd7;
      step();
      in_valid = 1'b0;
      check_uop(3, 8, 12, 16, 0, 2, 0);
      step();
      step();
      chk("mid_idx", 32'(uop_idx), 2);
      chk("mid_vd", 32'(uop_vd), 18);
      #2 rst = 1'b1;
      #1;
      chk("arst_uop_valid", 32'(uop_valid), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_uop_vd", 32'(uop_vd), 0);
      chk("arst_uop_idx", 32'(uop_idx), 0);
      chk("arst_in_ready", 32'(in_ready), 1);
      chk("arst_done", 32'(done), 0);
      step();
      rst = 1'b0;
      step();
      run_instr(10, 8, 12, 16, 2, 2, 7, 2, 1);

      for (int n = 0; n < 150; n++) begin
         sew  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
         lmul = $urandom_range(0, 7);
         L    = (lmul == 1) ? 2 : (lmul == 2) ? 4 : (lmul == 3) ? 8 : 1;
         b1   = $urandom_range(0, 31);
         b2   = $urandom_range(0, 31);
         b3   = $urandom_range(0, 31);
         if ($urandom_range(0, 3) != 0) begin
            b1 = b1 - b1 % L;
            b2 = b2 - b2 % L;
            b3 = b3 - b3 % L;
         end
         run_instr($urandom_range(0, 15), b1, b2, b3, sew, lmul,
                   ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 127),
                   $urandom_range(0, 7), $urandom_range(0, 3));
      end

      step();
      chk("final_done_low", 32'(done), 0);
      chk("final_err_low", 32'(err), 0);
      chk("final_idle", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
